ql_bram_preload_ctrl: RTL and testbench
=======================================

QL_BRAM_PRELOAD_CTRL -- requirements
Module: ql_bram_preload_ctrl

Interface
REQ-001 Parameter SETUP_CYCLES, default 4, CLK_i cycles of PL_INIT_o assertion before the first preload access (range 1..255).
REQ-002 CLK_i  input  1  single block clock; all logic rising-edge.
REQ-003 RESET_i  input  1  reset; synchronous and active-high.
REQ-004 START_i  input  1  one-cycle request to begin a preload session.
REQ-005 RAM_SEL_i  input  16  target RAM select, driven on PL_ADDR_o[31:16].
REQ-006 BASE_ADDR_i / WORD_CNT_i  input  16 each  first word address; number of words (0 legal).
REQ-007 WDATA_i  input  36 / WVALID_i  input  1 / WREADY_o  output  1  write-word stream, valid/ready.
REQ-008 BUSY_o  output  1  session active; DONE_o  output  1  one-cycle completion pulse.
REQ-009 ERR_o  output  1  sticky verify mismatch; ERR_ADDR_o  output  16  address of first mismatch.
REQ-010 PL_INIT_o, PL_ENA_o, PL_REN_o, PL_CLK_o  output  1 each; PL_WEN_o  output  2; PL_ADDR_o  output  32; PL_DATA_o  output  36  preload bus driven into the BRAM chain.
REQ-011 PL_DATA_i  input  36  readback data returned from the chain.

Function
REQ-012 States: IDLE, SETUP, W_WAIT, W_LO, W_HI, R_LO, R_HI, R_CAP, FINISH.
REQ-013 START_i sampled only in IDLE; ignored while BUSY_o=1; START_i latches RAM_SEL_i, BASE_ADDR_i, WORD_CNT_i.
REQ-014 WORD_CNT_i=0: IDLE->FINISH; BUSY_o high one cycle, DONE_o pulses next cycle, no PL_INIT_o/PL_ENA_o activity.
REQ-015 Otherwise IDLE->SETUP; PL_INIT_o rises the cycle after START_i and remains high SETUP_CYCLES cycles before W_WAIT.
REQ-016 W_WAIT: WREADY_o=1 (only state where it is 1); WVALID_i&WREADY_o captures WDATA_i, next state W_LO.
REQ-017 W_LO: PL_ENA_o=1, PL_WEN_o=2'b11, PL_CLK_o=0, PL_ADDR_o={sel,addr}, PL_DATA_o=captured word; W_HI: same with PL_CLK_o=1.
REQ-018 Without verify: W_HI -> W_WAIT (words remain) or FINISH; minimum 3 cycles/word.
REQ-019 Address increments by 1 after each word, modulo 2^16 (16'hFFFF wraps to 16'h0000); RAM_SEL never changes within a session.
REQ-020 PL_ENA_o, PL_WEN_o, PL_REN_o are 0 and PL_CLK_o is 0 in all states other than W_LO/W_HI/R_LO/R_HI.
REQ-021 FINISH: PL_INIT_o drops, DONE_o=1 for one cycle, BUSY_o=0 next cycle, return to IDLE.
REQ-022 BUSY_o=1 from the cycle after START_i through the FINISH cycle inclusive.
REQ-023 ERR_o/ERR_ADDR_o clear on an accepted START_i; hold value otherwise.

Reset
REQ-024 RESET_i=1 at a clock edge: state IDLE; all outputs 0 (PL_ADDR_o, PL_DATA_o, ERR_ADDR_o = 0) on the following cycle.
REQ-025 Reset mid-session aborts immediately: no DONE_o pulse, PL_INIT_o low next cycle, captured word discarded.

Configuration
REQ-026 Macro PL_READBACK_VERIFY_EN: defined -> after W_HI go R_LO (PL_ENA_o=1, PL_REN_o=1, PL_WEN_o=0, PL_CLK_o=0, same address), R_HI (PL_CLK_o=1), R_CAP (sample PL_DATA_i, compare to captured word), then W_WAIT/FINISH; 6 cycles/word minimum.
REQ-027 On first mismatch ERR_o=1 and ERR_ADDR_o=word address; later mismatches do not update ERR_ADDR_o; session continues to completion.
REQ-028 Macro undefined: R_* states absent, PL_REN_o tied 0, ERR_o and ERR_ADDR_o tied 0, PL_DATA_i unused.

Verification
REQ-029 SETUP_CYCLES=4, sel=16'h0003, base=16'h0010, cnt=3, WVALID always 1 -> PL_ADDR_o 32'h0003_0010/_0011/_0012, 3 PL_CLK_o pulses, DONE_o once, PL_INIT_o high exactly 4+9 cycles (no verify).
REQ-030 base=16'hFFFE, cnt=4 -> addresses FFFE, FFFF, 0000, 0001.
REQ-031 cnt=0 -> DONE_o one cycle after BUSY_o pulse, PL_INIT_o never asserted.
REQ-032 WVALID_i low 5 cycles in W_WAIT -> PL bus idle, WREADY_o held 1, no address advance.
REQ-033 Verify build, chain model corrupts word at 16'h0011 -> ERR_o=1, ERR_ADDR_o=16'h0011, DONE_o still pulses; next START clears ERR_o.
REQ-034 RESET_i asserted in W_HI of word 2 -> all outputs 0 next cycle, no DONE_o; new START runs cleanly.

Source files
------------

// File: rtl/ql_bram_preload_ctrl.sv
// BRAM preload controller: streams words from a valid/ready source onto the PL_* chain bus.
// Readback verification of every word is compiled in when PL_READBACK_VERIFY_EN is defined.
module ql_bram_preload_ctrl #(
  parameter int unsigned SETUP_CYCLES = 4
) (
  input  logic        CLK_i,
  input  logic        RESET_i,
  input  logic        START_i,
  input  logic [15:0] RAM_SEL_i,
  input  logic [15:0] BASE_ADDR_i,
  input  logic [15:0] WORD_CNT_i,
  input  logic [35:0] WDATA_i,
  input  logic        WVALID_i,
  output logic        WREADY_o,
  output logic        BUSY_o,
  output logic        DONE_o,
  output logic        ERR_o,
  output logic [15:0] ERR_ADDR_o,
  output logic        PL_INIT_o,
  output logic        PL_ENA_o,
  output logic        PL_REN_o,
  output logic        PL_CLK_o,
  output logic [1:0]  PL_WEN_o,
  output logic [31:0] PL_ADDR_o,
  output logic [35:0] PL_DATA_o,
  input  logic [35:0] PL_DATA_i
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, SETUP, W_WAIT, W_LO, W_HI, FINISH
`ifdef PL_READBACK_VERIFY_EN
    , R_LO, R_HI, R_CAP
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  setup_cnt_q, setup_cnt_d;
  logic [15:0] sel_q, sel_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] left_q, left_d;
  logic [35:0] word_q, word_d;
  logic        busy_q, busy_d;
  logic        init_q, init_d;
  logic        wready_q, wready_d;
  logic        ena_q, ena_d;
  logic        pclk_q, pclk_d;
  logic [1:0]  wen_q, wen_d;
  logic        done_q, done_d;
  logic        word_done;
  logic        wr_phase;
`ifdef PL_READBACK_VERIFY_EN
  logic        ren_q, ren_d;
  logic        err_q, err_d;
  logic [15:0] err_addr_q, err_addr_d;
  logic        rd_phase;
`endif

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    left_d      = left_q;
    word_d      = word_q;
    word_done   = 1'b0;
`ifdef PL_READBACK_VERIFY_EN
    err_d       = err_q;
    err_addr_d  = err_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (START_i) begin
          sel_d       = RAM_SEL_i;
          addr_d      = BASE_ADDR_i;
          left_d      = WORD_CNT_i;
          setup_cnt_d = SETUP_LAST;
`ifdef PL_READBACK_VERIFY_EN
          err_d       = 1'b0;
          err_addr_d  = 16'h0000;
`endif
          state_d     = (WORD_CNT_i == 16'h0000) ? FINISH : SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt_q == 8'h00) state_d = W_WAIT;
        else                      setup_cnt_d = setup_cnt_q - 8'd1;
      end
      W_WAIT: begin
        if (WVALID_i) begin
          word_d  = WDATA_i;
          state_d = W_LO;
        end
      end
      W_LO: state_d = W_HI;
`ifdef PL_READBACK_VERIFY_EN
      W_HI:  state_d = R_LO;
      R_LO:  state_d = R_HI;
      R_HI:  state_d = R_CAP;
      R_CAP: begin
        word_done = 1'b1;
        // Only the first mismatch of a session is recorded
        if ((PL_DATA_i != word_q) && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
        end
      end
`else
      W_HI:  word_done = 1'b1;
`endif
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (word_done) begin
      addr_d  = addr_q + 16'd1;
      left_d  = left_q - 16'd1;
      state_d = (left_q == 16'd1) ? FINISH : W_WAIT;
    end
  end

  // Outputs are decoded from the next state so they register in step with it
  always_comb begin
    busy_d   = (state_d != IDLE);
    init_d   = (state_d != IDLE) && (state_d != FINISH);
    wready_d = (state_d == W_WAIT);
    wr_phase = (state_d == W_LO) || (state_d == W_HI);
    ena_d    = wr_phase;
    pclk_d   = (state_d == W_HI);
    wen_d    = wr_phase ? 2'b11 : 2'b00;
    done_d   = (state_q == FINISH);
`ifdef PL_READBACK_VERIFY_EN
    rd_phase = (state_d == R_LO) || (state_d == R_HI);
    ena_d    = wr_phase || rd_phase;
    pclk_d   = (state_d == W_HI) || (state_d == R_HI);
    ren_d    = rd_phase;
`endif
  end

  always_ff @(posedge CLK_i) begin
    if (RESET_i) begin
      state_q     <= IDLE;
      setup_cnt_q <= 8'h00;
      sel_q       <= 16'h0000;
      addr_q      <= 16'h0000;
      left_q      <= 16'h0000;
      word_q      <= 36'h0;
      busy_q      <= 1'b0;
      init_q      <= 1'b0;
      wready_q    <= 1'b0;
      ena_q       <= 1'b0;
      pclk_q      <= 1'b0;
      wen_q       <= 2'b00;
      done_q      <= 1'b0;
`ifdef PL_READBACK_VERIFY_EN
      ren_q       <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      init_q      <= init_d;
      wready_q    <= wready_d;
      ena_q       <= ena_d;
      pclk_q      <= pclk_d;
      wen_q       <= wen_d;
      done_q      <= done_d;
`ifdef PL_READBACK_VERIFY_EN
      ren_q       <= ren_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
`endif
    end
  end

  assign WREADY_o  = wready_q;
  assign BUSY_o    = busy_q;
  assign DONE_o    = done_q;
  assign PL_INIT_o = init_q;
  assign PL_ENA_o  = ena_q;
  assign PL_CLK_o  = pclk_q;
  assign PL_WEN_o  = wen_q;
  assign PL_ADDR_o = {sel_q, addr_q};
  assign PL_DATA_o = word_q;
`ifdef PL_READBACK_VERIFY_EN
  assign PL_REN_o   = ren_q;
  assign ERR_o      = err_q;
  assign ERR_ADDR_o = err_addr_q;
`else
  logic unused_pl_data;
  assign unused_pl_data = ^PL_DATA_i;
  assign PL_REN_o   = 1'b0;
  assign ERR_o      = 1'b0;
  assign ERR_ADDR_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ql_bram_preload_ctrl.sv
// Self-checking bench for ql_bram_preload_ctrl: random word streams checked against a
// session-level model (expected write list, cycle totals, error capture).
module tb_ql_bram_preload_ctrl;
  localparam int SETUP = 4;
`ifdef PL_READBACK_VERIFY_EN
  localparam int WPW = 6;
  localparam int RD_PER_WORD = 1;
`else
  localparam int WPW = 3;
  localparam int RD_PER_WORD = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ram_sel = '0, base_addr = '0, word_cnt = '0;
  logic [35:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic        wready, busy, done, err;
  logic [15:0] err_addr;
  logic        pl_init, pl_ena, pl_ren, pl_clk;
  logic [1:0]  pl_wen;
  logic [31:0] pl_addr;
  logic [35:0] pl_data_o, pl_data_i;

  ql_bram_preload_ctrl #(.SETUP_CYCLES(SETUP)) dut (
    .CLK_i(clk), .RESET_i(reset), .START_i(start), .RAM_SEL_i(ram_sel),
    .BASE_ADDR_i(base_addr), .WORD_CNT_i(word_cnt), .WDATA_i(wdata),
    .WVALID_i(wvalid), .WREADY_o(wready), .BUSY_o(busy), .DONE_o(done),
    .ERR_o(err), .ERR_ADDR_o(err_addr), .PL_INIT_o(pl_init), .PL_ENA_o(pl_ena),
    .PL_REN_o(pl_ren), .PL_CLK_o(pl_clk), .PL_WEN_o(pl_wen), .PL_ADDR_o(pl_addr),
    .PL_DATA_o(pl_data_o), .PL_DATA_i(pl_data_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Chain model: memory written on PL_CLK rising edges, read back combinationally
  logic [35:0] mem [0:65535];
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_lo = '0, corrupt_hi = '0;
  assign pl_data_i = mem[pl_addr[15:0]] ^
      ((corrupt_en && pl_addr[15:0] >= corrupt_lo && pl_addr[15:0] <= corrupt_hi) ? 36'h1 : 36'h0);

  int m_cyc = 0, m_busy = 0, m_init = 0, m_done = 0, m_wready = 0, m_reads = 0;
  int m_viol = 0, m_ena = 0, m_last_busy = -1, m_done_cyc = -1;
  logic m_clk_prev = 1'b0;
  logic [67:0] m_wr[$];

  always begin
    @(posedge clk);
    #2;
    if (busy)   begin m_busy++; m_last_busy = m_cyc; end
    if (done)   begin m_done++; m_done_cyc = m_cyc; end
    if (pl_init) m_init++;
    if (wready)  m_wready++;
    if (pl_ena)  m_ena++;
    if (!pl_ena && (pl_wen != 2'b00 || pl_ren || pl_clk)) m_viol++;
    if (pl_ena && !pl_init) m_viol++;
    if (wready && pl_ena) m_viol++;
    if (pl_wen != 2'b00 && pl_ren) m_viol++;
    if (pl_clk && !m_clk_prev && pl_ena && pl_wen == 2'b11) begin
      m_wr.push_back({pl_addr, pl_data_o});
      mem[pl_addr[15:0]] = pl_data_o;
    end
    if (pl_clk && !m_clk_prev && pl_ena && pl_ren) m_reads++;
    m_clk_prev = pl_clk;
    m_cyc++;
  end

  logic [35:0] words[$];
  int s_busy, s_init, s_done, s_wready, s_reads, s_viol, s_ena, s_wr;

  task automatic take_snap();
    s_busy = m_busy; s_init = m_init; s_done = m_done; s_wready = m_wready;
    s_reads = m_reads; s_viol = m_viol; s_ena = m_ena; s_wr = m_wr.size();
  endtask

  // mode 0: WVALID always 1; 1: random WVALID; 2: five-cycle stall before word 1;
  // 3: extra START pulse with different parameters while busy
  task automatic drive_session(input logic [15:0] sel, input logic [15:0] base,
                               input logic [15:0] cnt, input int mode, output bit timed_out);
    int idx, stall;
    bit pending;
    logic [31:0] r1, r2;
    words.delete();
    for (int i = 0; i < int'(cnt); i++) begin
      r1 = $urandom; r2 = $urandom;
      words.push_back({r1[3:0], r2});
    end
    @(negedge clk);
    ram_sel = sel; base_addr = base; word_cnt = cnt; start = 1'b1; wvalid = 1'b0;
    idx = 0; stall = 0; pending = 1'b0; timed_out = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pending) idx++;
      if (done) begin timed_out = 1'b0; break; end
      if (idx < int'(cnt)) wdata = words[idx];
      else                 wdata = '0;
      case (mode)
        1: wvalid = 1'($urandom_range(0, 1));
        2: if (wready && idx == 1 && stall < 5) begin wvalid = 1'b0; stall++; end
           else wvalid = 1'b1;
        3: begin
          wvalid = 1'b1;
          if (c == 2) begin
            start = 1'b1; ram_sel = ~sel; base_addr = base + 16'd100; word_cnt = 16'd7;
          end
        end
        default: wvalid = 1'b1;
      endcase
      pending = wready && wvalid;
    end
    wvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, wready, err, pl_init, pl_ena, pl_ren, pl_clk, pl_wen, pl_addr, pl_data_o, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b init=%b addr=%h data=%h erra=%h expected all zero",
               busy, pl_init, pl_addr, pl_data_o, err_addr);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    logic [15:0] a;
    logic [67:0] exp;
    take_snap();
    drive_session(16'h0003, 16'h0010, 16'd3, 0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: DONE not seen within budget"); end
    checks++; if (m_wr.size() - s_wr != 3) begin errors++;
      $display("FAIL basic_write_count: got %0d expected 3", m_wr.size() - s_wr); end
    for (int i = 0; i < 3 && s_wr + i < m_wr.size(); i++) begin
      a = 16'h0010 + 16'(i);
      exp = {16'h0003, a, words[i]};
      checks++; if (m_wr[s_wr + i] !== exp) begin errors++;
        $display("FAIL basic_write%0d: got %h expected %h", i, m_wr[s_wr + i], exp); end
    end
    checks++; if (m_init - s_init != SETUP + 3 * WPW) begin errors++;
      $display("FAIL basic_init_cycles: got %0d expected %0d", m_init - s_init, SETUP + 3 * WPW); end
    checks++; if (m_busy - s_busy != SETUP + 3 * WPW + 1) begin errors++;
      $display("FAIL basic_busy_cycles: got %0d expected %0d", m_busy - s_busy, SETUP + 3 * WPW + 1); end
    checks++; if (m_done - s_done != 1) begin errors++;
      $display("FAIL basic_done_count: got %0d expected 1", m_done - s_done); end
    checks++; if (m_done_cyc != m_last_busy + 1) begin errors++;
      $display("FAIL basic_done_timing: got cycle %0d expected %0d", m_done_cyc, m_last_busy + 1); end
    checks++; if (m_viol != s_viol) begin errors++;
      $display("FAIL basic_bus_protocol: got %0d violations expected 0", m_viol - s_viol); end
    checks++; if (m_reads - s_reads != 3 * RD_PER_WORD) begin errors++;
      $display("FAIL basic_reads: got %0d expected %0d", m_reads - s_reads, 3 * RD_PER_WORD); end
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_wrap();
    bit to;
    logic [15:0] a, sel;
    logic [67:0] exp;
    sel = 16'($urandom);
    take_snap();
    drive_session(sel, 16'hFFFE, 16'd4, 1, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout: DONE not seen within budget"); end
    checks++; if (m_wr.size() - s_wr != 4) begin errors++;
      $display("FAIL wrap_write_count: got %0d expected 4", m_wr.size() - s_wr); end
    for (int i = 0; i < 4 && s_wr + i < m_wr.size(); i++) begin
      a = 16'hFFFE + 16'(i);
      exp = {sel, a, words[i]};
      checks++; if (m_wr[s_wr + i] !== exp) begin errors++;
        $display("FAIL wrap_write%0d: got %h expected %h", i, m_wr[s_wr + i], exp); end
    end
    checks++; if (m_done - s_done != 1) begin errors++;
      $display("FAIL wrap_done_count: got %0d expected 1", m_done - s_done); end
  endtask

  task automatic test_zero_count();
    bit to;
    take_snap();
    drive_session(16'($urandom), 16'($urandom), 16'd0, 0, to);
    checks++; if (to) begin errors++; $display("FAIL zero_timeout: DONE not seen within budget"); end
    checks++; if (m_busy - s_busy != 1) begin errors++;
      $display("FAIL zero_busy_cycles: got %0d expected 1", m_busy - s_busy); end
    checks++; if (m_init != s_init || m_ena != s_ena) begin errors++;
      $display("FAIL zero_bus_activity: got init=%0d ena=%0d expected 0 0", m_init - s_init, m_ena - s_ena); end
    checks++; if (m_done - s_done != 1 || m_done_cyc != m_last_busy + 1) begin errors++;
      $display("FAIL zero_done: got count=%0d cycle=%0d expected 1 at %0d",
               m_done - s_done, m_done_cyc, m_last_busy + 1); end
    checks++; if (m_wr.size() != s_wr) begin errors++;
      $display("FAIL zero_writes: got %0d expected 0", m_wr.size() - s_wr); end
  endtask

  task automatic test_stall();
    bit to;
    logic [15:0] a;
    logic [67:0] exp;
    take_snap();
    drive_session(16'h00A5, 16'h1230, 16'd3, 2, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout: DONE not seen within budget"); end
    checks++; if (m_init - s_init != SETUP + 3 * WPW + 5) begin errors++;
      $display("FAIL stall_init_cycles: got %0d expected %0d", m_init - s_init, SETUP + 3 * WPW + 5); end
    checks++; if (m_wready - s_wready != 3 + 5) begin errors++;
      $display("FAIL stall_wready_cycles: got %0d expected 8", m_wready - s_wready); end
    checks++; if (m_wr.size() - s_wr != 3) begin errors++;
      $display("FAIL stall_write_count: got %0d expected 3", m_wr.size() - s_wr); end
    for (int i = 0; i < 3 && s_wr + i < m_wr.size(); i++) begin
      a = 16'h1230 + 16'(i);
      exp = {16'h00A5, a, words[i]};
      checks++; if (m_wr[s_wr + i] !== exp) begin errors++;
        $display("FAIL stall_write%0d: got %h expected %h", i, m_wr[s_wr + i], exp); end
    end
    checks++; if (m_viol != s_viol) begin errors++;
      $display("FAIL stall_bus_protocol: got %0d violations expected 0", m_viol - s_viol); end
  endtask

  task automatic test_start_ignored();
    bit to;
    logic [15:0] a;
    logic [67:0] exp;
    take_snap();
    drive_session(16'h0042, 16'h0200, 16'd2, 3, to);
    checks++; if (to) begin errors++; $display("FAIL ignore_timeout: DONE not seen within budget"); end
    checks++; if (m_wr.size() - s_wr != 2) begin errors++;
      $display("FAIL ignore_write_count: got %0d expected 2", m_wr.size() - s_wr); end
    for (int i = 0; i < 2 && s_wr + i < m_wr.size(); i++) begin
      a = 16'h0200 + 16'(i);
      exp = {16'h0042, a, words[i]};
      checks++; if (m_wr[s_wr + i] !== exp) begin errors++;
        $display("FAIL ignore_write%0d: got %h expected %h", i, m_wr[s_wr + i], exp); end
    end
    checks++; if (m_busy - s_busy != SETUP + 2 * WPW + 1) begin errors++;
      $display("FAIL ignore_busy_cycles: got %0d expected %0d", m_busy - s_busy, SETUP + 2 * WPW + 1); end
  endtask

  task automatic test_random();
    bit to;
    logic [15:0] sel, base, cnt, a;
    logic [67:0] exp;
    for (int n = 0; n < 6; n++) begin
      sel  = 16'($urandom);
      base = (n % 2 == 0) ? 16'($urandom) : 16'hFFF8 + 16'($urandom_range(0, 7));
      cnt  = 16'($urandom_range(1, 8));
      take_snap();
      drive_session(sel, base, cnt, 1, to);
      checks++; if (to) begin errors++; $display("FAIL random%0d_timeout: DONE not seen within budget", n); end
      checks++; if (m_wr.size() - s_wr != int'(cnt)) begin errors++;
        $display("FAIL random%0d_write_count: got %0d expected %0d", n, m_wr.size() - s_wr, cnt); end
      for (int i = 0; i < int'(cnt) && s_wr + i < m_wr.size(); i++) begin
        a = base + 16'(i);
        exp = {sel, a, words[i]};
        checks++; if (m_wr[s_wr + i] !== exp) begin errors++;
          $display("FAIL random%0d_write%0d: got %h expected %h", n, i, m_wr[s_wr + i], exp); end
      end
      checks++; if (m_done - s_done != 1 || m_viol != s_viol) begin errors++;
        $display("FAIL random%0d_done_protocol: got done=%0d viol=%0d expected 1 0",
                 n, m_done - s_done, m_viol - s_viol); end
    end
  endtask

`ifdef PL_READBACK_VERIFY_EN
  task automatic test_verify();
    bit to;
    corrupt_en = 1'b1; corrupt_lo = 16'h0011; corrupt_hi = 16'h0012;
    take_snap();
    drive_session(16'h0003, 16'h0010, 16'd3, 0, to);
    corrupt_en = 1'b0;
    checks++; if (to) begin errors++; $display("FAIL verify_timeout: DONE not seen within budget"); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL verify_err: got %b expected 1", err); end
    checks++; if (err_addr !== 16'h0011) begin errors++;
      $display("FAIL verify_err_addr: got %h expected 0011", err_addr); end
    checks++; if (m_done - s_done != 1) begin errors++;
      $display("FAIL verify_done_count: got %0d expected 1", m_done - s_done); end
    drive_session(16'h0003, 16'h0000, 16'd0, 0, to);
    checks++; if (err !== 1'b0 || err_addr !== 16'h0000) begin errors++;
      $display("FAIL verify_err_clear: got err=%b addr=%h expected 0 0000", err, err_addr); end
  endtask
`endif

  task automatic test_reset_mid();
    bit found, to;
    logic [31:0] r;
    logic [15:0] a;
    logic [67:0] exp;
    take_snap();
    @(negedge clk);
    r = $urandom;
    ram_sel = 16'h0003; base_addr = 16'h0010; word_cnt = 16'd3; start = 1'b1;
    wvalid = 1'b1; wdata = {4'h5, r};
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (pl_clk && pl_wen == 2'b11 && pl_addr[15:0] == 16'h0011) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach: second word write phase not seen"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, wready, err, pl_init, pl_ena, pl_ren, pl_clk, pl_wen, pl_addr, pl_data_o, err_addr} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got busy=%b init=%b ena=%b addr=%h data=%h expected all zero",
               busy, pl_init, pl_ena, pl_addr, pl_data_o);
    end
    reset = 1'b0; wvalid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (m_done != s_done || pl_init !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL rst_mid_no_done: got done=%0d init=%b busy=%b expected 0 0 0",
               m_done - s_done, pl_init, busy); end
    take_snap();
    drive_session(16'h0007, 16'h0040, 16'd2, 0, to);
    checks++; if (to || m_done - s_done != 1 || m_wr.size() - s_wr != 2) begin errors++;
      $display("FAIL rst_mid_rerun: got timeout=%b done=%0d writes=%0d expected 0 1 2",
               to, m_done - s_done, m_wr.size() - s_wr); end
    for (int i = 0; i < 2 && s_wr + i < m_wr.size(); i++) begin
      a = 16'h0040 + 16'(i);
      exp = {16'h0007, a, words[i]};
      checks++; if (m_wr[s_wr + i] !== exp) begin errors++;
        $display("FAIL rst_mid_rerun_write%0d: got %h expected %h", i, m_wr[s_wr + i], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_count();
    test_stall();
    test_start_ignored();
    test_random();
`ifdef PL_READBACK_VERIFY_EN
    test_verify();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
